uart_cfg: RTL and testbench
===========================

# uart_cfg

Parametrised successor to the basic UART core: full-duplex serial transceiver with an internal baud-tick generator, 16x oversampling, and TX/RX FIFOs. Parity mode and stop-bit count are selectable at run time. Each received word carries per-word parity and framing error flags, and a sticky overrun flag is provided. Sits between a CPU/bus-side register block and the board UART pins.

## Interface
- DBIT, 8, data bits per frame (5..9); also the width of w_data/r_data
- FIFO_W, 2, FIFO address bits; each FIFO is 2^FIFO_W words deep
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dvsr  in  11  baud divisor; one oversample tick every dvsr+1 clocks
- cfg_par  in  2  parity: 00 none, 01 even, 10 odd, 11 none
- cfg_stop2  in  1  0: one stop bit, 1: two stop bits
- wr_uart  in  1  push w_data into the TX FIFO
- w_data  in  DBIT  transmit word
- rd_uart  in  1  pop the head of the RX FIFO
- clr_err  in  1  clear the sticky overrun flag
- rx  in  1  serial input (asynchronous)
- tx  out  1  serial output, idle high
- tx_full  out  1  TX FIFO full
- tx_busy  out  1  TX FIFO non-empty, or a frame is in flight
- rx_empty  out  1  RX FIFO empty
- r_data  out  DBIT  RX FIFO head (show-ahead)
- r_perr  out  1  parity error flag of the head word
- r_ferr  out  1  framing error flag of the head word
- overrun  out  1  sticky: a received word was dropped because the RX FIFO was full

## Operation
- Reset values:
  - tx=1, tx_full=0, tx_busy=0, rx_empty=1, overrun=0.
  - r_data, r_perr and r_ferr are 0 while empty after reset.
  - Both FIFOs are emptied; the rx synchronizer flops are set to 1.
- Tick generator:
  - Counter counts 0..dvsr. Tick pulses for one clock on the cycle the counter reaches dvsr or above, then the counter returns to 0.
  - dvsr=0 gives a tick every clock.
  - dvsr changes take effect immediately.
- FIFOs:
  - Write when full is ignored. Read when empty is ignored.
  - Simultaneous read and write when full: both happen, count unchanged.
  - Simultaneous read and write when empty: write only.
  - RX FIFO entry is {ferr, perr, data}.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the TX FIFO is non-empty, pop the head, latch cfg_par and cfg_stop2, go to START.
  - START (tx=0): 16 ticks.
  - DATA: DBIT bits, LSB first, 16 ticks each.
  - PARITY: present only when parity is enabled; 16 ticks. Bit is the XOR of the data for even parity, inverted for odd.
  - STOP (tx=1): 16 ticks, or 32 ticks when cfg_stop2=1.
  - Then back to IDLE; a back-to-back frame starts on the next tick-independent IDLE cycle.
- RX path: rx passes through a 2-flop synchronizer (rs). RX FSM uses the same states.
  - IDLE: rs=0 → START. Latch cfg_par and cfg_stop2; clear the tick count.
  - START: at tick 7, if rs=0 → DATA with count cleared; if rs=1 it is a false start → IDLE.
  - DATA: sample rs at tick 15 of each bit. Bits shift in LSB first.
  - PARITY: sample the parity bit at tick 15. perr=1 if it mismatches the configured parity; perr is 0 when parity is disabled.
  - STOP: sample at tick 15 of the first stop bit. ferr=1 if the sample is 0. With cfg_stop2=1, the second stop bit is not checked.
  - After the stop sample: push {ferr, perr, data}, go to IDLE. The receiver does not wait out the remainder of the stop bit(s).
- Overrun:
  - A push while the RX FIFO is full drops the word and sets overrun.
  - A simultaneous rd_uart and push when full is not an overrun.
  - overrun is cleared by clr_err. If clr_err and a new overrun event occur in the same cycle, overrun stays 1.
- Configuration changes mid-frame do not affect the frame in flight; they apply from the next frame.
- A reset asserted mid-frame aborts both FSMs; all outputs take their reset values on the next clock.

## Timing
- Bit period = 16*(dvsr+1) clocks.
- Frame length = (1 + DBIT + P + S)*16*(dvsr+1) clocks, where P is 1 when parity is enabled and S is 1 or 2.
- wr_uart at cycle n:
  - tx_busy=1 at n+1.
  - tx falls (start bit) at n+2 when the TX FSM is idle; start-bit length is then aligned to ticks.
- RX latency: the pushed word is visible (rx_empty=0, r_data valid) one clock after the stop-bit sample tick.
- rd_uart at cycle n: the next head word (or rx_empty=1) appears at n+1.
- tx_full asserts in the cycle after the write that fills the FIFO.
- tx_busy deasserts the cycle after the last STOP tick when the TX FIFO is empty.

## Test plan
- Reset, then dvsr=1, cfg_par=00, cfg_stop2=0, write 0xA5 with tx looped to rx:
  - tx low for 32 clocks, then bits 1,0,1,0,0,1,0,1 at 32 clocks each, then high for 32 clocks.
  - r_data=0xA5, r_perr=0, r_ferr=0.
- cfg_par=01 then 10 with 0xA5, loopback:
  - Parity bit is 0 for 01 and 1 for 10; no perr in either case.
  - Bench flips the parity bit → r_perr=1 with r_data=0xA5.
- Bench drives a 0x3C frame with the stop bit at 0 → r_ferr=1 and r_data=0x3C.
  - A 4-tick low glitch on rx → nothing pushed; rx_empty stays 1.
- FIFO_W=2: receive 5 words 0x01..0x05 without reading:
  - overrun=1; reads return 0x01..0x04, then rx_empty=1.
  - clr_err → overrun=0.
- Write 6 words with dvsr=0: tx_full=1 after 4 are queued; extra writes ignored per the full rule.
  - cfg_stop2=1 → each stop period is 32 clocks.
- Assert reset halfway through a data bit → next clock tx=1, tx_busy=0, rx_empty=1.
  - A subsequent 0x5A frame transmits correctly.

Source files
------------

// File: rtl/uart_cfg.sv
// Full-duplex UART with baud-tick generator, 16x oversampling, run-time parity/stop
// selection, and show-ahead TX/RX FIFOs carrying per-word parity/framing flags.

module uart_cfg_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wptr_r;
  logic [AW:0]  rptr_r;
  logic         wr_en_s;
  logic         rd_en_s;

  // Occupancy flags and accept rules; a read frees a slot for a same-cycle write.
  always_comb begin
    empty   = (wptr_r == rptr_r);
    full    = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    rd_en_s = rd && !empty;
    wr_en_s = wr && (!full || rd_en_s);
    rdata   = empty ? {W{1'b0}} : mem_r[rptr_r[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) wptr_r <= wptr_r + PTR_ONE;
      if (rd_en_s) rptr_r <= rptr_r + PTR_ONE;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wptr_r[AW-1:0]] <= wdata;
  end
endmodule

module uart_cfg #(
  parameter int DBIT   = 8,
  parameter int FIFO_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [10:0]     dvsr,
  input  logic [1:0]      cfg_par,
  input  logic            cfg_stop2,
  input  logic            wr_uart,
  input  logic [DBIT-1:0] w_data,
  input  logic            rd_uart,
  input  logic            clr_err,
  input  logic            rx,
  output logic            tx,
  output logic            tx_full,
  output logic            tx_busy,
  output logic            rx_empty,
  output logic [DBIT-1:0] r_data,
  output logic            r_perr,
  output logic            r_ferr,
  output logic            overrun
);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] LAST_BIT = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;

  function automatic logic par_bit(input logic [DBIT-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // ---------------- tick generator and rx synchronizer ----------------
  logic [10:0] tick_cnt_r;
  logic        tick_s;
  logic        rx_meta_r;
  logic        rs_r;

  assign tick_s = (tick_cnt_r >= dvsr);

  // Oversample tick counter; compares against live dvsr so changes apply at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_r <= 11'd0;
      rx_meta_r  <= 1'b1;
      rs_r       <= 1'b1;
    end else begin
      tick_cnt_r <= tick_s ? 11'd0 : tick_cnt_r + 11'd1;
      rx_meta_r  <= rx;
      rs_r       <= rx_meta_r;
    end
  end

  // ---------------- transmitter ----------------
  state_t          tx_state_r, tx_state_n;
  logic [4:0]      tx_s_r, tx_s_n;
  logic [NW-1:0]   tx_n_r, tx_n_n;
  logic [DBIT-1:0] tx_b_r, tx_b_n;
  logic            tx_pbit_r, tx_pbit_n;
  logic            tx_pen_r, tx_pen_n;
  logic            tx_stop2_r, tx_stop2_n;
  logic            tx_r, tx_bit_s;
  logic            tf_rd_s, tf_empty;
  logic [DBIT-1:0] tf_dout;

  uart_cfg_fifo #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr(wr_uart), .wdata(w_data), .rd(tf_rd_s),
    .rdata(tf_dout), .full(tx_full), .empty(tf_empty)
  );

  // TX next-state; frame settings are captured when the word is popped.
  always_comb begin
    tx_state_n = tx_state_r;
    tx_s_n     = tx_s_r;
    tx_n_n     = tx_n_r;
    tx_b_n     = tx_b_r;
    tx_pbit_n  = tx_pbit_r;
    tx_pen_n   = tx_pen_r;
    tx_stop2_n = tx_stop2_r;
    tf_rd_s    = 1'b0;
    case (tx_state_r)
      IDLE: begin
        if (!tf_empty) begin
          tf_rd_s    = 1'b1;
          tx_b_n     = tf_dout;
          tx_pen_n   = cfg_par[0] ^ cfg_par[1];
          tx_pbit_n  = par_bit(tf_dout, cfg_par[1]);
          tx_stop2_n = cfg_stop2;
          tx_s_n     = 5'd0;
          tx_state_n = START;
        end else begin
          tx_state_n = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          if (tx_s_r == 5'd15) begin
            tx_s_n     = 5'd0;
            tx_n_n     = {NW{1'b0}};
            tx_state_n = DATA;
          end else begin
            tx_s_n = tx_s_r + 5'd1;
          end
        end else begin
          tx_s_n = tx_s_r;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (tx_s_r == 5'd15) begin
            tx_s_n = 5'd0;
            tx_b_n = {1'b0, tx_b_r[DBIT-1:1]};
            if (tx_n_r == LAST_BIT) begin
              tx_state_n = tx_pen_r ? PARITY : STOP;
            end else begin
              tx_n_n = tx_n_r + {{(NW-1){1'b0}}, 1'b1};
            end
          end else begin
            tx_s_n = tx_s_r + 5'd1;
          end
        end else begin
          tx_s_n = tx_s_r;
        end
      end
      PARITY: begin
        if (tick_s) begin
          if (tx_s_r == 5'd15) begin
            tx_s_n     = 5'd0;
            tx_state_n = STOP;
          end else begin
            tx_s_n = tx_s_r + 5'd1;
          end
        end else begin
          tx_s_n = tx_s_r;
        end
      end
      STOP: begin
        if (tick_s) begin
          if (tx_s_r == (tx_stop2_r ? 5'd31 : 5'd15)) begin
            tx_state_n = IDLE;
          end else begin
            tx_s_n = tx_s_r + 5'd1;
          end
        end else begin
          tx_s_n = tx_s_r;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // Line level for the upcoming state, so tx is registered alongside the state.
  always_comb begin
    tx_bit_s = 1'b1;
    case (tx_state_n)
      START:   tx_bit_s = 1'b0;
      DATA:    tx_bit_s = tx_b_n[0];
      PARITY:  tx_bit_s = tx_pbit_n;
      default: tx_bit_s = 1'b1;
    endcase
  end

  // Transmitter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r <= IDLE;
      tx_s_r     <= 5'd0;
      tx_n_r     <= {NW{1'b0}};
      tx_b_r     <= {DBIT{1'b0}};
      tx_pbit_r  <= 1'b0;
      tx_pen_r   <= 1'b0;
      tx_stop2_r <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      tx_state_r <= tx_state_n;
      tx_s_r     <= tx_s_n;
      tx_n_r     <= tx_n_n;
      tx_b_r     <= tx_b_n;
      tx_pbit_r  <= tx_pbit_n;
      tx_pen_r   <= tx_pen_n;
      tx_stop2_r <= tx_stop2_n;
      tx_r       <= tx_bit_s;
    end
  end

  assign tx      = tx_r;
  assign tx_busy = (tx_state_r != IDLE) || !tf_empty;

  // ---------------- receiver ----------------
  state_t          rx_state_r, rx_state_n;
  logic [3:0]      rx_s_r, rx_s_n;
  logic [NW-1:0]   rx_n_r, rx_n_n;
  logic [DBIT-1:0] rx_b_r, rx_b_n;
  logic            rx_perr_r, rx_perr_n;
  logic            rx_pen_r, rx_pen_n;
  logic            rx_odd_r, rx_odd_n;
  logic            rx_push_s;
  logic            rf_full;
  logic [DBIT+1:0] rf_din, rf_dout;
  logic            ovr_evt_s;
  logic            overrun_r;

  // RX next-state; the word is pushed on the first stop-bit sample.
  always_comb begin
    rx_state_n = rx_state_r;
    rx_s_n     = rx_s_r;
    rx_n_n     = rx_n_r;
    rx_b_n     = rx_b_r;
    rx_perr_n  = rx_perr_r;
    rx_pen_n   = rx_pen_r;
    rx_odd_n   = rx_odd_r;
    rx_push_s  = 1'b0;
    rf_din     = {~rs_r, rx_perr_r, rx_b_r};
    case (rx_state_r)
      IDLE: begin
        if (!rs_r) begin
          rx_s_n     = 4'd0;
          rx_pen_n   = cfg_par[0] ^ cfg_par[1];
          rx_odd_n   = cfg_par[1];
          rx_perr_n  = 1'b0;
          rx_state_n = START;
        end else begin
          rx_state_n = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          if (rx_s_r == 4'd7) begin
            rx_s_n     = 4'd0;
            rx_n_n     = {NW{1'b0}};
            rx_state_n = rs_r ? IDLE : DATA;
          end else begin
            rx_s_n = rx_s_r + 4'd1;
          end
        end else begin
          rx_s_n = rx_s_r;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (rx_s_r == 4'd15) begin
            rx_s_n = 4'd0;
            rx_b_n = {rs_r, rx_b_r[DBIT-1:1]};
            if (rx_n_r == LAST_BIT) begin
              rx_state_n = rx_pen_r ? PARITY : STOP;
            end else begin
              rx_n_n = rx_n_r + {{(NW-1){1'b0}}, 1'b1};
            end
          end else begin
            rx_s_n = rx_s_r + 4'd1;
          end
        end else begin
          rx_s_n = rx_s_r;
        end
      end
      PARITY: begin
        if (tick_s) begin
          if (rx_s_r == 4'd15) begin
            rx_s_n     = 4'd0;
            rx_perr_n  = rs_r ^ par_bit(rx_b_r, rx_odd_r);
            rx_state_n = STOP;
          end else begin
            rx_s_n = rx_s_r + 4'd1;
          end
        end else begin
          rx_s_n = rx_s_r;
        end
      end
      STOP: begin
        if (tick_s) begin
          if (rx_s_r == 4'd15) begin
            rx_push_s  = 1'b1;
            rx_state_n = IDLE;
          end else begin
            rx_s_n = rx_s_r + 4'd1;
          end
        end else begin
          rx_s_n = rx_s_r;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_r <= IDLE;
      rx_s_r     <= 4'd0;
      rx_n_r     <= {NW{1'b0}};
      rx_b_r     <= {DBIT{1'b0}};
      rx_perr_r  <= 1'b0;
      rx_pen_r   <= 1'b0;
      rx_odd_r   <= 1'b0;
    end else begin
      rx_state_r <= rx_state_n;
      rx_s_r     <= rx_s_n;
      rx_n_r     <= rx_n_n;
      rx_b_r     <= rx_b_n;
      rx_perr_r  <= rx_perr_n;
      rx_pen_r   <= rx_pen_n;
      rx_odd_r   <= rx_odd_n;
    end
  end

  uart_cfg_fifo #(.W(DBIT + 2), .AW(FIFO_W)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr(rx_push_s), .wdata(rf_din), .rd(rd_uart),
    .rdata(rf_dout), .full(rf_full), .empty(rx_empty)
  );

  assign r_ferr = rf_dout[DBIT+1];
  assign r_perr = rf_dout[DBIT];
  assign r_data = rf_dout[DBIT-1:0];

  // A same-cycle read makes room, so only an unserved push to a full FIFO is lost.
  assign ovr_evt_s = rx_push_s && rf_full && !rd_uart;

  // Sticky overrun; a new event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (ovr_evt_s) begin
      overrun_r <= 1'b1;
    end else if (clr_err) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign overrun = overrun_r;
endmodule

// File: tb/tb_uart_cfg.sv
// Self-checking bench for uart_cfg: directed/table RX frames, loopback TX frames checked
// bit-by-bit against a parity/framing model, FIFO full/overrun and mid-frame reset.

module tb_uart_cfg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [10:0] dvsr = 11'd1;
  logic [1:0]  cfg_par = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic        wr_uart = 1'b0;
  logic [7:0]  w_data = 8'h00;
  logic        rd_uart = 1'b0;
  logic        clr_err = 1'b0;
  logic        loop = 1'b0;
  logic        rx_drv = 1'b1;
  logic        rx_in;
  logic        tx, tx_full, tx_busy, rx_empty, r_perr, r_ferr, overrun;
  logic [7:0]  r_data;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int fall_t = 0;

  assign rx_in = loop ? tx : rx_drv;

  uart_cfg #(.DBIT(8), .FIFO_W(2)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .cfg_par(cfg_par), .cfg_stop2(cfg_stop2),
    .wr_uart(wr_uart), .w_data(w_data), .rd_uart(rd_uart), .clr_err(clr_err), .rx(rx_in),
    .tx(tx), .tx_full(tx_full), .tx_busy(tx_busy), .rx_empty(rx_empty), .r_data(r_data),
    .r_perr(r_perr), .r_ferr(r_ferr), .overrun(overrun)
  );

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [7:0] data;
    logic [1:0] par;
    logic       stop2;
    logic       flip;
    logic       stopv;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } rx_vec_t;

  rx_vec_t vecs[8];

  // Reference rules: even parity = XOR of data, odd = its inverse; parity on for 01/10.
  function automatic logic par_of(input logic [7:0] d, input logic [1:0] p);
    return (^d) ^ (p == 2'b10);
  endfunction

  function automatic logic par_on(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  function automatic int bp();
    return 16 * (int'(dvsr) + 1);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Bench-driven serial frame on rx; a low stop bit is released early so the line idles.
  task automatic drive_frame(input logic [7:0] d, input logic [1:0] p, input logic s2,
                             input logic flip, input logic stopv);
    int b;
    b = bp();
    rx_drv = 1'b0; cyc(b);
    for (int i = 0; i < 8; i++) begin rx_drv = d[i]; cyc(b); end
    if (par_on(p)) begin rx_drv = par_of(d, p) ^ flip; cyc(b); end
    rx_drv = stopv;
    cyc(stopv ? b : (b * 3) / 4);
    rx_drv = 1'b1;
    cyc(stopv ? 0 : b / 4);
    if (s2) cyc(b);
    cyc(b);
  endtask

  task automatic pop_check(input string nm, input logic [7:0] d, input logic pe, input logic fe);
    check({nm, "_nonempty"}, 32'(rx_empty), 32'd0);
    check({nm, "_data"}, 32'(r_data), 32'(d));
    check({nm, "_perr"}, 32'(r_perr), 32'(pe));
    check({nm, "_ferr"}, 32'(r_ferr), 32'(fe));
    rd_uart = 1'b1; cyc(1); rd_uart = 1'b0;
  endtask

  // Waits for a start bit, then samples every field mid-bit against the expected frame.
  task automatic check_tx(input string nm, input logic [7:0] d, input logic [1:0] p, input logic s2);
    int b;
    int n;
    int lo;
    b = bp();
    n = 0;
    while (tx !== 1'b0 && n < 4000) begin cyc(1); n++; end
    fall_t = cyc_cnt;
    if (tx !== 1'b0) begin
      check({nm, "_start_timeout"}, 32'(tx), 32'd0);
      return;
    end
    if (d[0]) begin
      lo = 0;
      while (tx === 1'b0 && lo < 4 * b) begin cyc(1); lo++; end
      check_range({nm, "_start_len"}, lo, b - int'(dvsr), b);
      cyc(b / 2);
    end else begin
      cyc(b / 2);
      check({nm, "_start"}, 32'(tx), 32'd0);
      cyc(b);
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_bit%0d", nm, i), 32'(tx), 32'(d[i]));
      cyc(b);
    end
    if (par_on(p)) begin
      check({nm, "_parity"}, 32'(tx), 32'(par_of(d, p)));
      cyc(b);
    end
    check({nm, "_stop1"}, 32'(tx), 32'd1);
    if (s2) begin
      cyc(b);
      check({nm, "_stop2"}, 32'(tx), 32'd1);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < 4000) begin cyc(1); n++; end
    check({nm, "_busy_clear"}, 32'(tx_busy), 32'd0);
    check({nm, "_tx_idle"}, 32'(tx), 32'd1);
  endtask

  // One word through the transmitter with tx looped back into rx.
  task automatic tx_loop(input string nm, input logic [7:0] d, input logic [1:0] p, input logic s2);
    cfg_par = p; cfg_stop2 = s2; loop = 1'b1;
    wr_uart = 1'b1; w_data = d; cyc(1); wr_uart = 1'b0;
    check({nm, "_busy_n1"}, 32'(tx_busy), 32'd1);
    check({nm, "_tx_n1"}, 32'(tx), 32'd1);
    cyc(1);
    check({nm, "_tx_n2"}, 32'(tx), 32'd0);
    check_tx(nm, d, p, s2);
    cyc(bp() / 2 + 4);
    pop_check(nm, d, 1'b0, 1'b0);
    check({nm, "_drained"}, 32'(rx_empty), 32'd1);
    wait_idle(nm);
  endtask

  initial begin
    logic [7:0] q[$];
    logic       ovr_exp;
    int         falls[5];
    logic [7:0] d;
    logic [1:0] p;
    logic       s2, fl, sv;

    vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 2'b01, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 2'b10, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[3] = '{8'hA5, 2'b10, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 2'b01, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{8'h5A, 2'b01, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1};

    cyc(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_r_data", 32'(r_data), 32'd0);
    check("rst_r_perr", 32'(r_perr), 32'd0);
    check("rst_r_ferr", 32'(r_ferr), 32'd0);
    reset = 1'b0;
    cyc(2);

    // Loopback 0xA5 with no parity, even and odd parity.
    tx_loop("lb_none", 8'hA5, 2'b00, 1'b0);
    tx_loop("lb_even", 8'hA5, 2'b01, 1'b0);
    tx_loop("lb_odd", 8'hA5, 2'b10, 1'b0);

    // Bench-driven receive vectors.
    loop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_par = vecs[i].par; cfg_stop2 = vecs[i].stop2;
      drive_frame(vecs[i].data, vecs[i].par, vecs[i].stop2, vecs[i].flip, vecs[i].stopv);
      pop_check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
      check($sformatf("vec%0d_drained", i), 32'(rx_empty), 32'd1);
    end

    // A 4-tick glitch is rejected as a false start.
    cfg_par = 2'b00; cfg_stop2 = 1'b0;
    rx_drv = 1'b0; cyc(4 * (int'(dvsr) + 1)); rx_drv = 1'b1;
    cyc(3 * bp());
    check("glitch_empty", 32'(rx_empty), 32'd1);

    // Five words into a 4-deep RX FIFO with no reads.
    ovr_exp = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive_frame(8'(i), 2'b00, 1'b0, 1'b0, 1'b1);
      if (q.size() < 4) q.push_back(8'(i));
      else ovr_exp = 1'b1;
    end
    check("ovr_set", 32'(overrun), 32'(ovr_exp));
    while (q.size() > 0) begin
      d = q.pop_front();
      pop_check($sformatf("ovr_rd%0d", d), d, 1'b0, 1'b0);
    end
    check("ovr_drained", 32'(rx_empty), 32'd1);
    clr_err = 1'b1; cyc(1); clr_err = 1'b0;
    check("ovr_clear", 32'(overrun), 32'd0);

    // Six back-to-back writes at dvsr=0 with two stop bits; the sixth meets a full FIFO.
    dvsr = 11'd0; cfg_par = 2'b00; cfg_stop2 = 1'b1; loop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_uart = 1'b1; w_data = 8'(16 * (i + 1)); cyc(1);
      if (i == 3) check("full_after4", 32'(tx_full), 32'd0);
      if (i >= 4) check($sformatf("full_after%0d", i + 1), 32'(tx_full), 32'd1);
    end
    wr_uart = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_tx($sformatf("q%0d", k), 8'(16 * (k + 1)), 2'b00, 1'b1);
      falls[k] = fall_t;
      if (k >= 2) check($sformatf("q%0d_period", k), 32'(falls[k] - falls[k-1]), 32'd177);
    end
    wait_idle("q_end");

    // Reset halfway through a data bit aborts the frame.
    dvsr = 11'd1; cfg_stop2 = 1'b0; loop = 1'b1;
    wr_uart = 1'b1; w_data = 8'h5A; cyc(1); wr_uart = 1'b0;
    cyc(2 + 2 * bp() + bp() / 2);
    reset = 1'b1; cyc(1);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_empty", 32'(rx_empty), 32'd1);
    reset = 1'b0; cyc(2);
    tx_loop("post_rst", 8'h5A, 2'b00, 1'b0);

    // Randomized loopback frames.
    for (int i = 0; i < 10; i++) begin
      dvsr = 11'($urandom_range(0, 2));
      d = 8'($urandom); p = 2'($urandom_range(0, 3)); s2 = 1'($urandom_range(0, 1));
      tx_loop($sformatf("rnd_lb%0d", i), d, p, s2);
    end

    // Randomized bench-driven frames with injected parity/framing errors.
    loop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dvsr = 11'($urandom_range(1, 2));
      d = 8'($urandom); p = 2'($urandom_range(0, 3)); s2 = 1'($urandom_range(0, 1));
      fl = 1'($urandom_range(0, 1)); sv = 1'($urandom_range(0, 1));
      cfg_par = p; cfg_stop2 = s2;
      drive_frame(d, p, s2, fl, sv);
      pop_check($sformatf("rnd_rx%0d", i), d, par_on(p) & fl, ~sv);
    end
    check("end_empty", 32'(rx_empty), 32'd1);
    check("end_overrun", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
